music_seq_ctrl: RTL
===================

// Module: music_seq_ctrl
// PURPOSE
//   Note sequencer for the music player. Takes one-cycle key pulses from the
//   syn_circ synchronisers (play/pause, next) and a beat tick from the clock
//   divider, walks the song ROM, and drives the note code and enable to the
//   tone generator. Sits between the input synchronisers and the song ROM.
// PARAMETERS
//   ADDR_W     5   song ROM address width
//   NOTE_W     4   note code width (0 = rest)
//   DUR_W      4   duration field width, in beats (0 = end-of-song marker)
//   SONG_LEN   32  number of valid ROM entries, 1..2**ADDR_W
//   GAP_TICKS  1   silent beats inserted after every note, >= 1
// PORTS
//   clk         in   1              system clock
//   reset       in   1              asynchronous reset, active-high
//   play_pulse  in   1              1-cycle pulse from syn_circ: start / pause / resume
//   next_pulse  in   1              1-cycle pulse from syn_circ: skip to next note
//   beat_tick   in   1              1-cycle pulse, one per beat
//   rom_data    in   NOTE_W+DUR_W   {note, dur}; valid 1 cycle after rom_addr
//   rom_addr    out  ADDR_W         song ROM address
//   note        out  NOTE_W         current note code to tone generator
//   note_en     out  1              tone generator enable
//   playing     out  1              high in FETCH/LATCH/PLAY/GAP
//   song_done   out  1              1-cycle pulse on song completion
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, rom_addr=0, note=0, note_en=0,
//     playing=0, song_done=0, dur_cnt=0, gap_cnt=0. All outputs registered.
//   - States: IDLE, FETCH, LATCH, PLAY, GAP, PAUSE, DONE.
//   - IDLE: play_pulse -> FETCH. next_pulse and beat_tick ignored.
//   - FETCH: present rom_addr; 1 cycle -> LATCH (covers ROM read latency).
//   - LATCH: if dur==0 -> DONE. Else note<=rom_data note, dur_cnt<=dur -> PLAY.
//   - PLAY: note_en=1 (0 if note==0, rest). beat_tick decrements dur_cnt;
//     tick with dur_cnt==1 -> GAP, gap_cnt<=GAP_TICKS, note_en<=0.
//   - GAP: note_en=0; beat_tick decrements gap_cnt; tick at gap_cnt==1 ->
//     advance: if rom_addr==SONG_LEN-1 -> DONE, else rom_addr+1, -> FETCH.
//   - next_pulse in PLAY or GAP: immediate advance (same rule as GAP end);
//     remaining duration discarded, note_en<=0 next cycle.
//   - play_pulse in PLAY or GAP -> PAUSE; note_en=0, dur_cnt/gap_cnt/rom_addr
//     frozen, beat_tick ignored. play_pulse in PAUSE -> back to saved state
//     (PLAY or GAP), note_en restored, counters resume. next_pulse in PAUSE:
//     ignored.
//   - play_pulse in FETCH/LATCH: ignored (transient states).
//   - Priority same cycle: play_pulse > next_pulse > beat_tick.
//   - DONE: song_done=1 for exactly one cycle, rom_addr<=0, -> IDLE.
//   - Counters never wrap: dur_cnt/gap_cnt only decrement on tick while >=1.
//   - Latency: play_pulse in IDLE -> note_en high 3 cycles later (FETCH,
//     LATCH, PLAY entry registered).
// TESTING
//   1. ROM {3,2},{5,1},{0,0}, GAP_TICKS=1: play -> note 3 for 2 ticks, gap 1
//      tick, note 5 for 1 tick, gap, song_done pulse once, rom_addr back to 0.
//   2. Pause: play pulse mid-note 3 after 1 tick -> note_en=0, 5 ticks ignored;
//      play again -> note 3 resumes for exactly 1 more tick.
//   3. next_pulse mid-note -> rom_addr+1 next cycle, note_en low through
//      FETCH/LATCH, new note after 2 cycles; next at last entry -> song_done.
//   4. play_pulse and next_pulse in same cycle in PLAY -> PAUSE, rom_addr held.
//   5. Assert reset mid-PLAY between clock edges -> outputs zero immediately,
//      state IDLE; beat_tick/next after release ignored until play_pulse.
//   6. Full 32-entry song without end marker -> wraps to DONE after entry 31,
//      rom_addr=0, playing=0.

Source files
------------

// File: rtl/music_seq_ctrl.sv
// Note sequencer for the music player.
// It takes play/next key pulses and the beat tick, steps through the song ROM
// and drives the note code and enable to the tone generator.
// Every output comes straight from a register.
module music_seq_ctrl #(
    parameter int ADDR_W    = 5,
    parameter int NOTE_W    = 4,
    parameter int DUR_W     = 4,
    parameter int SONG_LEN  = 32,
    parameter int GAP_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play_pulse,
    input  logic                    next_pulse,
    input  logic                    beat_tick,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [ADDR_W-1:0]       rom_addr,
    output logic [NOTE_W-1:0]       note,
    output logic                    note_en,
    output logic                    playing,
    output logic                    song_done
);

    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        PLAY  = 3'd3,
        GAP   = 3'd4,
        PAUSE = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t              state_reg, state_next;
    logic                resume_gap_reg, resume_gap_next;  // 1: pause was entered from GAP
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [NOTE_W-1:0]   note_reg, note_next;
    logic                note_en_reg, note_en_next;
    logic                playing_reg, playing_next;
    logic                done_reg, done_next;
    logic [DUR_W-1:0]    dur_cnt_reg, dur_cnt_next;
    logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
    logic                do_advance;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            resume_gap_reg <= 1'b0;
            addr_reg       <= '0;
            note_reg       <= '0;
            note_en_reg    <= 1'b0;
            playing_reg    <= 1'b0;
            done_reg       <= 1'b0;
            dur_cnt_reg    <= '0;
            gap_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            resume_gap_reg <= resume_gap_next;
            addr_reg       <= addr_next;
            note_reg       <= note_next;
            note_en_reg    <= note_en_next;
            playing_reg    <= playing_next;
            done_reg       <= done_next;
            dur_cnt_reg    <= dur_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
        end
    end

    // Next state and next output values.
    // When inputs arrive in the same cycle, play_pulse wins over next_pulse,
    // and next_pulse wins over beat_tick.
    always_comb begin
        state_next      = state_reg;
        resume_gap_next = resume_gap_reg;
        addr_next       = addr_reg;
        note_next       = note_reg;
        note_en_next    = note_en_reg;
        dur_cnt_next    = dur_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        do_advance      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (play_pulse) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // rom_addr is already presented; wait one cycle for the ROM read
                state_next = LATCH;
            end
            LATCH: begin
                if (rom_dur == '0) begin
                    state_next = DONE;
                    addr_next  = '0;
                end else begin
                    note_next    = rom_note;
                    dur_cnt_next = rom_dur;
                    note_en_next = (rom_note != '0);
                    state_next   = PLAY;
                end
            end
            PLAY: begin
                if (play_pulse) begin
                    state_next      = PAUSE;
                    resume_gap_next = 1'b0;
                    note_en_next    = 1'b0;
                end else if (next_pulse) begin
                    do_advance = 1'b1;
                end else if (beat_tick && dur_cnt_reg != '0) begin
                    if (dur_cnt_reg == DUR_W'(1)) begin
                        state_next   = GAP;
                        dur_cnt_next = '0;
                        gap_cnt_next = GAP_W'(GAP_TICKS);
                        note_en_next = 1'b0;
                    end else begin
                        dur_cnt_next = dur_cnt_reg - DUR_W'(1);
                    end
                end
            end
            GAP: begin
                if (play_pulse) begin
                    state_next      = PAUSE;
                    resume_gap_next = 1'b1;
                end else if (next_pulse) begin
                    do_advance = 1'b1;
                end else if (beat_tick && gap_cnt_reg != '0) begin
                    if (gap_cnt_reg == GAP_W'(1)) begin
                        gap_cnt_next = '0;
                        do_advance   = 1'b1;
                    end else begin
                        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                    end
                end
            end
            PAUSE: begin
                // Counters and address stay frozen; only play_pulse matters here
                if (play_pulse) begin
                    state_next   = resume_gap_reg ? GAP : PLAY;
                    note_en_next = !resume_gap_reg && (note_reg != '0);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Leaving a note early (next_pulse) or normally (gap over) follows one rule
        if (do_advance) begin
            note_en_next = 1'b0;
            if (addr_reg == LAST_ADDR) begin
                state_next = DONE;
                addr_next  = '0;
            end else begin
                state_next = FETCH;
                addr_next  = addr_reg + ADDR_W'(1);
            end
        end

        playing_next = (state_next == FETCH) || (state_next == LATCH) ||
                       (state_next == PLAY)  || (state_next == GAP);
        done_next    = (state_next == DONE);
    end

    assign rom_addr  = addr_reg;
    assign note      = note_reg;
    assign note_en   = note_en_reg;
    assign playing   = playing_reg;
    assign song_done = done_reg;

endmodule
